// File: rtl/awgn_pkg.sv
// Shared constants for the LFSR generator/checker pair: word width, feedback taps
// and the checker state encoding.
package awgn_pkg;

   localparam int unsigned WORD_W = 32;

   // Feedback taps of the Fibonacci polynomial
   localparam int unsigned TAP_A = 31;
   localparam int unsigned TAP_B = 21;
   localparam int unsigned TAP_C = 1;
   localparam int unsigned TAP_D = 0;

   // Encoding 2'd3 is unused; the checker recovers from it to StSearch
   typedef enum logic [1:0] {
      StSearch = 2'd0,
      StVerify = 2'd1,
      StLocked = 2'd2
   } state_t;

endpackage

// File: rtl/lfsr_step.sv
// One-clock advance of the Fibonacci LFSR: shift left, XOR of the taps enters bit 0.
// Purely combinational so the generator can share it.
module lfsr_step
   import awgn_pkg::*;
(
   input  logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q
);

   assign q = {d[WORD_W-2:0], d[TAP_A] ^ d[TAP_B] ^ d[TAP_C] ^ d[TAP_D]};

endmodule

// File: rtl/lfsr_checker.sv
// Locks onto an LFSR word stream, then flywheels the prediction and counts mismatching
// words. Lock is declared after LOCK_COUNT matches and dropped after UNLOCK_ERRS
// consecutive misses.
module lfsr_checker
   import awgn_pkg::*;
#(
   parameter int unsigned LOCK_COUNT  = 8,
   parameter int unsigned UNLOCK_ERRS = 4,
   parameter int unsigned ERR_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] data,
   input  logic              valid,
   output logic              locked,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_count,
   output logic [1:0]        state
);

   localparam logic [7:0] LOCK_CNT8   = 8'(LOCK_COUNT);
   localparam logic [7:0] UNLOCK_CNT8 = 8'(UNLOCK_ERRS);

   state_t            state_q, state_d;
   logic [WORD_W-1:0] pred_q, pred_d;
   logic [WORD_W-1:0] seed_next, pred_next;
   logic [7:0]        match_cnt_q, match_cnt_d;
   logic [7:0]        miss_cnt_q, miss_cnt_d;
   logic [ERR_W-1:0]  err_count_q, err_count_d;
   logic              err_pulse_q, err_pulse_d;
   logic              locked_q;
   logic              hit;

   // Seed path: prediction restarted from the received word
   lfsr_step u_seed_step (
      .d (data),
      .q (seed_next)
   );

   // Prediction path: free-running flywheel
   lfsr_step u_pred_step (
      .d (pred_q),
      .q (pred_next)
   );

   assign hit = (data == pred_q);

   // Next-state, prediction and counter updates for one accepted word
   always_comb begin
      state_d     = state_q;
      pred_d      = pred_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_count_d = err_count_q;
      err_pulse_d = 1'b0;
      case (state_q)
         StSearch: begin
            // All-zero is the LFSR lockup value and can never seed a valid stream
            if (valid && (data != '0)) begin
               pred_d      = seed_next;
               match_cnt_d = 8'd0;
               state_d     = StVerify;
            end
         end
         StVerify: begin
            if (valid) begin
               if (hit) begin
                  pred_d      = pred_next;
                  match_cnt_d = match_cnt_q + 8'd1;
                  if (match_cnt_d == LOCK_CNT8) begin
                     state_d    = StLocked;
                     miss_cnt_d = 8'd0;
                  end
               end else if (data == '0) begin
                  state_d = StSearch;
               end else begin
                  pred_d      = seed_next;
                  match_cnt_d = 8'd0;
               end
            end
         end
         StLocked: begin
            if (valid) begin
               // Never reseed while locked, so isolated bit errors do not lose alignment
               pred_d = pred_next;
               if (hit) begin
                  miss_cnt_d = 8'd0;
               end else begin
                  miss_cnt_d  = miss_cnt_q + 8'd1;
                  err_pulse_d = 1'b1;
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + ERR_W'(1);
                  end
                  if (miss_cnt_d == UNLOCK_CNT8) begin
                     state_d = StSearch;
                  end
               end
            end
         end
         default: state_d = StSearch;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StSearch;
         pred_q      <= '0;
         match_cnt_q <= 8'd0;
         miss_cnt_q  <= 8'd0;
         err_count_q <= '0;
         err_pulse_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pred_q      <= pred_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_count_q <= err_count_d;
         err_pulse_q <= err_pulse_d;
         locked_q    <= (state_d == StLocked);
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized self-checking bench for lfsr_checker with a behavioural stream model.
module tb_lfsr_checker;

   localparam int LOCK_N   = 8;
   localparam int UNLOCK_N = 4;
   localparam int ERR_MAX  = 65535;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data, data2;
   logic        valid, valid2;
   logic        locked, locked2;
   logic        err_pulse, err_pulse2;
   logic [15:0] err_count;
   logic [3:0]  err_count2;
   logic [1:0]  state, state2;

   always #5 clk = ~clk;

   lfsr_checker u_dut (
      .clk       (clk),
      .reset     (reset),
      .data      (data),
      .valid     (valid),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .state     (state)
   );

   lfsr_checker #(
      .LOCK_COUNT  (8),
      .UNLOCK_ERRS (255),
      .ERR_W       (4)
   ) u_sat (
      .clk       (clk),
      .reset     (reset),
      .data      (data2),
      .valid     (valid2),
      .locked    (locked2),
      .err_pulse (err_pulse2),
      .err_count (err_count2),
      .state     (state2)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model of the main instance: phase 0 hunting, 1 confirming, 2 tracking
   int          m_phase;
   logic [31:0] m_next;
   int          m_hits, m_misses, m_errs;
   bit          m_pulse;
   logic [31:0] gen;

   function automatic logic [31:0] gen_next(input logic [31:0] x);
      logic [31:0] fb;
      fb = ((x >> 31) ^ (x >> 21) ^ (x >> 1) ^ x) & 32'd1;
      return (x << 1) | fb;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_next = '0; m_hits = 0; m_misses = 0; m_errs = 0; m_pulse = 0;
   endtask

   task automatic model_accept(input logic v, input logic [31:0] w);
      bit miss;
      m_pulse = 0;
      if (v) begin
         if (m_phase == 0) begin
            if (w != 0) begin m_next = gen_next(w); m_hits = 0; m_phase = 1; end
         end else if (m_phase == 1) begin
            if (w == m_next) begin
               m_next = gen_next(m_next);
               m_hits++;
               if (m_hits == LOCK_N) begin m_phase = 2; m_misses = 0; end
            end else if (w == 0) begin
               m_phase = 0;
            end else begin
               m_next = gen_next(w); m_hits = 0;
            end
         end else begin
            miss   = (w != m_next);
            m_next = gen_next(m_next);
            if (miss) begin
               m_misses++;
               m_pulse = 1;
               if (m_errs < ERR_MAX) m_errs++;
               if (m_misses == UNLOCK_N) m_phase = 0;
            end else begin
               m_misses = 0;
            end
         end
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] w);
      @(negedge clk);
      valid = v; data = w; valid2 = 1'b0;
      @(posedge clk);
      #1;
      model_accept(v, w);
   endtask

   task automatic drive2(input logic [31:0] w);
      @(negedge clk);
      valid = 1'b0; valid2 = 1'b1; data2 = w;
      @(posedge clk);
      #1;
      model_accept(1'b0, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; valid = 1'b0; valid2 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0 || state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_main got l=%b p=%b e=%0d s=%0d want all 0",
                  locked, err_pulse, err_count, state);
      end
      n_tests++;
      if (locked2 !== 1'b0 || err_pulse2 !== 1'b0 || err_count2 !== 4'd0 || state2 !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_sat got l=%b p=%b e=%0d s=%0d want all 0",
                  locked2, err_pulse2, err_count2, state2);
      end
   endtask

   task automatic test_lock(input logic [31:0] seed);
      do_reset();
      gen = seed;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, gen);
         gen = gen_next(gen);
         n_tests++;
         if (locked !== (i >= 8) || err_count !== 16'd0 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL lock word=%0d got l=%b e=%0d p=%b want l=%b e=0 p=0",
                     i, locked, err_count, err_pulse, (i >= 8));
         end
      end
      n_tests++;
      if (state !== 2'd2) begin
         n_fail++;
         $display("FAIL lock_state got %0d want 2", state);
      end
   endtask

   task automatic test_flywheel();
      drive(1'b1, gen ^ 32'd1);
      gen = gen_next(gen);
      n_tests++;
      if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL flywheel_err got p=%b e=%0d l=%b want p=1 e=1 l=1",
                  err_pulse, err_count, locked);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, gen);
         gen = gen_next(gen);
         n_tests++;
         if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL flywheel_clean i=%0d got p=%b e=%0d l=%b s=%0d want p=0 e=1 l=1 s=2",
                     i, err_pulse, err_count, locked, state);
         end
      end
   endtask

   task automatic test_unlock();
      int base;
      base = m_errs;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, gen ^ (32'd1 << $urandom_range(0, 31)));
         gen = gen_next(gen);
         n_tests++;
         if (err_pulse !== 1'b1 || err_count !== 16'(base + k + 1) || locked !== (k < 3)) begin
            n_fail++;
            $display("FAIL unlock_miss k=%0d got p=%b e=%0d l=%b want p=1 e=%0d l=%b",
                     k, err_pulse, err_count, locked, base + k + 1, (k < 3));
         end
      end
      n_tests++;
      if (state !== 2'd0) begin
         n_fail++;
         $display("FAIL unlock_state got %0d want 0", state);
      end
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, gen);
         gen = gen_next(gen);
         n_tests++;
         if (locked !== (i >= 8) || err_count !== 16'(base + 4) || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL relock i=%0d got l=%b e=%0d p=%b want l=%b e=%0d p=0",
                     i, locked, err_count, err_pulse, (i >= 8), base + 4);
         end
      end
   endtask

   task automatic test_gaps();
      logic v;
      do_reset();
      gen = $urandom | 32'd1;
      for (int c = 0; c < 18; c++) begin
         v = ((c % 2) == 0);
         drive(v, v ? gen : $urandom);
         if (v) gen = gen_next(gen);
         n_tests++;
         if (locked !== (c >= 16) || err_pulse !== 1'b0 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL gaps c=%0d got l=%b p=%b e=%0d want l=%b p=0 e=0",
                     c, locked, err_pulse, err_count, (c >= 16));
         end
      end
   endtask

   task automatic test_zero();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'd0);
         n_tests++;
         if (state !== 2'd0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_search i=%0d got s=%0d l=%b want s=0 l=0", i, state, locked);
         end
      end
      drive(1'b1, $urandom | 32'd1);
      n_tests++;
      if (state !== 2'd1) begin
         n_fail++;
         $display("FAIL zero_seed got s=%0d want 1", state);
      end
      drive(1'b1, 32'd0);
      n_tests++;
      if (state !== 2'd0) begin
         n_fail++;
         $display("FAIL zero_verify got s=%0d want 0", state);
      end
   endtask

   task automatic test_async_reset();
      test_lock($urandom | 32'd1);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, ~gen);
         gen = gen_next(gen);
      end
      n_tests++;
      if (err_count !== 16'd3 || locked !== 1'b1 || err_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_pre got e=%0d l=%b p=%b want e=3 l=1 p=1",
                  err_count, locked, err_pulse);
      end
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0 || state !== 2'd0) begin
         n_fail++;
         $display("FAIL areset got l=%b p=%b e=%0d s=%0d want all 0",
                  locked, err_pulse, err_count, state);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_saturate();
      int want;
      do_reset();
      gen = $urandom | 32'd1;
      for (int i = 0; i < 9; i++) begin
         drive2(gen);
         gen = gen_next(gen);
      end
      n_tests++;
      if (locked2 !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_lock got l=%b want 1", locked2);
      end
      for (int k = 0; k < 20; k++) begin
         drive2(gen ^ 32'h8000_0000);
         gen = gen_next(gen);
         want = (k + 1 < 15) ? k + 1 : 15;
         n_tests++;
         if (err_count2 !== 4'(want) || err_pulse2 !== 1'b1 || locked2 !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate k=%0d got e=%0d p=%b l=%b want e=%0d p=1 l=1",
                     k, err_count2, err_pulse2, locked2, want);
         end
      end
   endtask

   task automatic test_random();
      logic        v;
      logic [31:0] w;
      int          r;
      do_reset();
      gen = $urandom | 32'd1;
      for (int c = 0; c < 400; c++) begin
         v = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 99);
         if (r < 80)      w = gen;
         else if (r < 92) w = gen ^ (32'd1 << $urandom_range(0, 31));
         else if (r < 96) w = 32'd0;
         else             w = $urandom;
         if ($urandom_range(0, 60) == 0) gen = $urandom | 32'd1;
         drive(v, w);
         if (v) gen = gen_next(gen);
         n_tests++;
         if (locked !== (m_phase == 2) || err_pulse !== m_pulse ||
             err_count !== 16'(m_errs) || state !== 2'(m_phase)) begin
            n_fail++;
            $display("FAIL random c=%0d got l=%b p=%b e=%0d s=%0d want l=%b p=%b e=%0d s=%0d",
                     c, locked, err_pulse, err_count, state,
                     (m_phase == 2), m_pulse, m_errs, m_phase);
         end
      end
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; valid2 = 1'b0; data = '0; data2 = '0;
      model_reset();
      test_reset();
      test_lock(32'h1);
      test_flywheel();
      test_unlock();
      test_lock($urandom | 32'd1);
      test_gaps();
      test_zero();
      test_async_reset();
      test_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
